// File: rtl/sumador_pkg.sv
// Shared elaboration helpers for the segmented adder.
//   params_ok  : legality of a WIDTH/CHUNK pair
//   num_stages : pipeline depth (one register stage per CHUNK-bit slice)
package sumador_pkg;

  // Slices must tile the word exactly.
  function automatic bit params_ok(input int unsigned width, input int unsigned chunk);
    return (chunk >= 1) && (chunk <= width) && ((width % chunk) == 0);
  endfunction

  // Guarded so an illegal chunk of zero still elaborates far enough to report.
  function automatic int unsigned num_stages(input int unsigned width, input int unsigned chunk);
    return (chunk == 0) ? 1 : width / chunk;
  endfunction

endpackage

// File: rtl/sumador_bloque.sv
// Combinational CHUNK-bit ripple slice of the segmented adder.
//   a, b : slice operands
//   cin  : carry into the slice
//   suma : slice sum
//   cout : carry out of the slice
module sumador_bloque #(
  parameter int unsigned CHUNK = 4
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             cin,
  output logic [CHUNK-1:0] suma,
  output logic             cout
);

  localparam int unsigned EW = CHUNK + 1;

  assign {cout, suma} = EW'(a) + EW'(b) + EW'(cin);

endmodule

// File: rtl/sumador_segmentado.sv
// Pipelined WIDTH-bit add/subtract unit, one register stage per CHUNK-bit slice.
//   clk, rst            : clock, synchronous active-high reset
//   in_valid, in_ready  : operand handshake (in_ready is combinational)
//   a, b, cin, sub      : operands; sub=1 computes a-b and ignores cin
//   out_valid, out_ready: result handshake with backpressure
//   sum, cout, overflow : registered result, raw carry, signed overflow
module sumador_segmentado
  import sumador_pkg::*;
#(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             overflow
);

  localparam int unsigned STAGES = num_stages(WIDTH, CHUNK);
  localparam int unsigned MSB    = WIDTH - 1;

  if (!params_ok(WIDTH, CHUNK)) begin : g_param_check
    $error("sumador_segmentado: WIDTH must be a multiple of CHUNK with 1 <= CHUNK <= WIDTH");
  end

  logic             adv_c;
  logic [WIDTH-1:0] b_eff_c;
  logic             cin_eff_c;

  // Per-stage registers: valid, partial result, carry, and the operand words
  // whose upper slices are still waiting to be added (skewed pipeline).
  logic             v_q [STAGES];
  logic             c_q [STAGES];
  logic [WIDTH-1:0] r_q [STAGES];
  logic [WIDTH-1:0] a_q [STAGES];
  logic [WIDTH-1:0] b_q [STAGES];
  logic             ovf_q;

  logic [CHUNK-1:0] op_a_c [STAGES];
  logic [CHUNK-1:0] op_b_c [STAGES];
  logic [CHUNK-1:0] suma_c [STAGES];
  logic             ci_c   [STAGES];
  logic             co_c   [STAGES];

  logic             a_msb_c;
  logic             b_msb_c;
  logic             ovf_c;

  // The whole pipeline moves as one; only in_ready is combinational.
  assign adv_c     = ~out_valid | out_ready;
  assign in_ready  = adv_c;

  // Subtraction folds into addition: a + ~b + 1.
  assign b_eff_c   = sub ? ~b : b;
  assign cin_eff_c = sub ? 1'b1 : cin;

  for (genvar s = 0; s < STAGES; s++) begin : g_slice
    if (s == 0) begin : g_first
      assign op_a_c[s] = a[CHUNK-1:0];
      assign op_b_c[s] = b_eff_c[CHUNK-1:0];
      assign ci_c[s]   = cin_eff_c;

      // Stage 1: capture slice 0 result plus the full operands for later slices.
      always_ff @(posedge clk) begin
        if (rst) begin
          v_q[s] <= 1'b0;
          c_q[s] <= 1'b0;
          r_q[s] <= '0;
          a_q[s] <= '0;
          b_q[s] <= '0;
        end else if (adv_c) begin
          v_q[s] <= in_valid;
          c_q[s] <= co_c[s];
          r_q[s] <= WIDTH'(suma_c[s]);
          a_q[s] <= a;
          b_q[s] <= b_eff_c;
        end
      end
    end else begin : g_rest
      assign op_a_c[s] = a_q[s-1][s*CHUNK +: CHUNK];
      assign op_b_c[s] = b_q[s-1][s*CHUNK +: CHUNK];
      assign ci_c[s]   = c_q[s-1];

      // Later stages: add the next slice and append it above the lower result bits.
      always_ff @(posedge clk) begin
        if (rst) begin
          v_q[s] <= 1'b0;
          c_q[s] <= 1'b0;
          r_q[s] <= '0;
          a_q[s] <= '0;
          b_q[s] <= '0;
        end else if (adv_c) begin
          v_q[s]                   <= v_q[s-1];
          c_q[s]                   <= co_c[s];
          r_q[s]                   <= r_q[s-1];
          r_q[s][s*CHUNK +: CHUNK] <= suma_c[s];
          a_q[s]                   <= a_q[s-1];
          b_q[s]                   <= b_q[s-1];
        end
      end
    end

    sumador_bloque #(
      .CHUNK (CHUNK)
    ) u_bloque (
      .a    (op_a_c[s]),
      .b    (op_b_c[s]),
      .cin  (ci_c[s]),
      .suma (suma_c[s]),
      .cout (co_c[s])
    );
  end

  // Operand MSBs as seen by the final slice.
  if (STAGES == 1) begin : g_msb_direct
    assign a_msb_c = a[MSB];
    assign b_msb_c = b_eff_c[MSB];
  end else begin : g_msb_carried
    assign a_msb_c = a_q[STAGES-2][MSB];
    assign b_msb_c = b_q[STAGES-2][MSB];
  end

  // Signed overflow: like-signed operands producing an opposite-signed result.
  assign ovf_c = (a_msb_c == b_msb_c) & (suma_c[STAGES-1][CHUNK-1] != a_msb_c);

  always_ff @(posedge clk) begin
    if (rst) begin
      ovf_q <= 1'b0;
    end else if (adv_c) begin
      ovf_q <= ovf_c;
    end
  end

  assign out_valid = v_q[STAGES-1];
  assign sum       = r_q[STAGES-1];
  assign cout      = c_q[STAGES-1];
  assign overflow  = ovf_q;

endmodule

// File: tb/tb_sumador_segmentado.sv
// Self-checking bench for sumador_segmentado (WIDTH=16, CHUNK=4).
module tb_sumador_segmentado;

  localparam int unsigned WIDTH  = 16;
  localparam int unsigned CHUNK  = 4;
  localparam int          STAGES = 4;

  logic              clk;
  logic              rst;
  logic              in_valid;
  logic              in_ready;
  logic [WIDTH-1:0]  a;
  logic [WIDTH-1:0]  b;
  logic              cin;
  logic              sub;
  logic              out_valid;
  logic              out_ready;
  logic [WIDTH-1:0]  sum;
  logic              cout;
  logic              overflow;

  typedef struct packed {
    logic [15:0] sum;
    logic        cout;
    logic        ovf;
  } exp_t;

  typedef struct packed {
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic        sub;
    logic [15:0] esum;
    logic        ecout;
    logic        eovf;
  } vec_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  sumador_segmentado #(
    .WIDTH (WIDTH),
    .CHUNK (CHUNK)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .sub       (sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .overflow  (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference arithmetic on the whole word.
  function automatic exp_t model(input logic [15:0] a_i, input logic [15:0] b_i,
                                 input logic cin_i, input logic sub_i);
    logic [15:0] be;
    logic [16:0] full;
    exp_t        e;
    be    = sub_i ? ~b_i : b_i;
    full  = {1'b0, a_i} + {1'b0, be} + 17'(sub_i ? 1'b1 : cin_i);
    e.sum  = full[15:0];
    e.cout = full[16];
    e.ovf  = (a_i[15] == be[15]) && (e.sum[15] != a_i[15]);
    return e;
  endfunction

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b1; a = 16'h1234; b = 16'h4321;
    cin = 1'b1; sub = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk);
      @(negedge clk);
      checks++;
      if ({out_valid, sum, cout, overflow} !== 19'd0) begin
        errors++;
        $display("FAIL reset_state: out_valid=%b sum=%h cout=%b ovf=%b, want 0 0000 0 0",
                 out_valid, sum, cout, overflow);
      end
    end
    rst = 1'b0; in_valid = 1'b0;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_in_ready: got %b want 1", in_ready);
    end
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b0) begin
        errors++;
        $display("FAIL reset_ghost: out_valid=%b at cycle %0d after release, want 0", out_valid, i);
      end
    end
  endtask

  task automatic test_directed();
    vec_t v[8];
    exp_t e;
    int   lat;
    v[0] = '{16'h00FF, 16'h0001, 1'b0, 1'b0, 16'h0100, 1'b0, 1'b0};
    v[1] = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0};
    v[2] = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1};
    v[3] = '{16'h0001, 16'h0002, 1'b1, 1'b0, 16'h0004, 1'b0, 1'b0};
    v[4] = '{16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0};
    v[5] = '{16'h0007, 16'h0005, 1'b0, 1'b1, 16'h0002, 1'b1, 1'b0};
    v[6] = '{16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1};
    v[7] = '{16'h0F0F, 16'h00F1, 1'b1, 1'b0, 16'h1001, 1'b0, 1'b0};
    out_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      @(posedge clk);
      #1;
      a = v[k].a; b = v[k].b; cin = v[k].cin; sub = v[k].sub; in_valid = 1'b1;
      @(negedge clk);
      if (in_valid && in_ready) sb.push_back('{v[k].esum, v[k].ecout, v[k].eovf});
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      lat = 0;
      for (int n = 1; n <= 8; n++) begin
        @(negedge clk);
        if (out_valid === 1'b1) begin
          lat = n;
          break;
        end
      end
      checks++;
      if (lat != STAGES) begin
        errors++;
        $display("FAIL latency_vec%0d: got %0d cycles want %0d", k, lat, STAGES);
      end
      if (lat != 0 && sb.size() > 0) begin
        e = sb.pop_front();
        checks++;
        if ({sum, cout, overflow} !== {e.sum, e.cout, e.ovf}) begin
          errors++;
          $display("FAIL result_vec%0d: got sum=%h cout=%b ovf=%b want sum=%h cout=%b ovf=%b",
                   k, sum, cout, overflow, e.sum, e.cout, e.ovf);
        end
      end else if (sb.size() > 0) begin
        void'(sb.pop_front());
      end
    end
  endtask

  task automatic test_back_to_back();
    int          sent = 0;
    int          got = 0;
    int          cyc = 0;
    bit          acc;
    bit          stalled_prev = 1'b0;
    logic [15:0] sum_prev = '0;
    logic        cout_prev = 1'b0;
    logic        ovf_prev = 1'b0;
    exp_t        e;
    @(posedge clk);
    #1;
    a = 16'($urandom); b = 16'($urandom); cin = 1'($urandom); sub = 1'($urandom);
    in_valid = 1'b1;
    while (got < 8 && cyc < 300) begin
      out_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
      checks++;
      if (in_ready !== !(out_valid && !out_ready)) begin
        errors++;
        $display("FAIL stream_in_ready: got %b with out_valid=%b out_ready=%b", in_ready, out_valid, out_ready);
      end
      if (stalled_prev) begin
        checks++;
        if (out_valid !== 1'b1 || {sum, cout, overflow} !== {sum_prev, cout_prev, ovf_prev}) begin
          errors++;
          $display("FAIL stall_hold: got v=%b sum=%h cout=%b ovf=%b want v=1 sum=%h cout=%b ovf=%b",
                   out_valid, sum, cout, overflow, sum_prev, cout_prev, ovf_prev);
        end
      end
      if (out_valid === 1'b1 && out_ready) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL stream_extra: unexpected result sum=%h, scoreboard empty", sum);
        end else begin
          e = sb.pop_front();
          if ({sum, cout, overflow} !== {e.sum, e.cout, e.ovf}) begin
            errors++;
            $display("FAIL stream_result%0d: got sum=%h cout=%b ovf=%b want sum=%h cout=%b ovf=%b",
                     got, sum, cout, overflow, e.sum, e.cout, e.ovf);
          end
        end
        got++;
      end
      stalled_prev = (out_valid === 1'b1) && !out_ready;
      sum_prev = sum; cout_prev = cout; ovf_prev = overflow;
      acc = in_valid && in_ready;
      if (acc) begin
        sb.push_back(model(a, b, cin, sub));
        sent++;
      end
      @(posedge clk);
      #1;
      cyc++;
      if (acc) begin
        if (sent < 8) begin
          a = 16'($urandom); b = 16'($urandom); cin = 1'($urandom); sub = 1'($urandom);
        end else begin
          in_valid = 1'b0;
        end
      end
    end
    checks++;
    if (got != 8 || sb.size() != 0) begin
      errors++;
      $display("FAIL stream_count: got %0d results, %0d pending, want 8 and 0", got, sb.size());
    end
    out_ready = 1'b1;
  endtask

  task automatic test_reset_midflight();
    exp_t e;
    int   lat;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    a = 16'h1111; b = 16'h2222; cin = 1'b0; sub = 1'b0; in_valid = 1'b1;
    sb.push_back(model(a, b, cin, sub));
    @(posedge clk);
    #1;
    a = 16'h3333; b = 16'h0001; sub = 1'b1;
    sb.push_back(model(a, b, cin, sub));
    @(posedge clk);
    #1;
    a = 16'h4444; b = 16'h4444; sub = 1'b0; rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0; in_valid = 1'b0;
    sb.delete();
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL midflight_flush: out_valid=%b after reset, want 0", out_valid);
    end
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b0) begin
        errors++;
        $display("FAIL midflight_ghost: out_valid=%b sum=%h at cycle %0d, want 0", out_valid, sum, i);
      end
    end
    @(posedge clk);
    #1;
    a = 16'h1234; b = 16'h1111; cin = 1'b0; sub = 1'b0; in_valid = 1'b1;
    sb.push_back('{16'h2345, 1'b0, 1'b0});
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    lat = 0;
    for (int n = 1; n <= 8; n++) begin
      @(negedge clk);
      if (out_valid === 1'b1) begin
        lat = n;
        break;
      end
    end
    checks++;
    if (lat != STAGES) begin
      errors++;
      $display("FAIL midflight_latency: got %0d cycles want %0d", lat, STAGES);
    end
    if (lat != 0) begin
      e = sb.pop_front();
      checks++;
      if ({sum, cout, overflow} !== {e.sum, e.cout, e.ovf}) begin
        errors++;
        $display("FAIL midflight_result: got sum=%h cout=%b ovf=%b want sum=%h cout=%b ovf=%b",
                 sum, cout, overflow, e.sum, e.cout, e.ovf);
      end
    end
    sb.delete();
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; cin = 1'b0; sub = 1'b0; out_ready = 1'b1;
    test_reset();
    test_directed();
    test_back_to_back();
    test_reset_midflight();
    repeat (2) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
